// File: rtl/ecube_route_if.sv
// ecube_route_if: valid/ready bundle between the XOR stage, the e-cube route stage and the five output channels.
//   master: drives in_valid/in_xor/in_data and out_ready; observes in_ready, out_valid, out_data, out_xor_rem, fifo_count
//   slave : the route stage itself (opposite directions)
interface ecube_route_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
);
   localparam int PTR_W = $clog2(DEPTH);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_xor;
   logic [DATA_W-1:0] in_data;
   logic [4:0]        out_valid;
   logic [4:0]        out_ready;
   logic [DATA_W-1:0] out_data;
   logic [3:0]        out_xor_rem;
   logic [PTR_W:0]    fifo_count;
   modport master (
      output in_valid, in_xor, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_xor_rem, fifo_count
   );
   modport slave (
      input  in_valid, in_xor, in_data, out_ready,
      output in_ready, out_valid, out_data, out_xor_rem, fifo_count
   );
endinterface

// File: rtl/ecube_route_stage.sv
// ecube_route_stage: FIFO-buffered e-cube output selector for a 16-node hypercube router.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (empties the FIFO)
//   rt       : ecube_route_if.slave -- input flit + XOR vector, five one-hot output channels, occupancy
//   Optional (macro ECUBE_ROUTE_STATS_EN):
//     stat_clr : synchronous clear of the per-port pop counters
//     stat_cnt : five saturating 16-bit pop counters, port p at [16p+15:16p]
module ecube_route_stage #(
   parameter int  DATA_W = 8,
   parameter int  DEPTH  = 4,
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input logic          clk,
   input logic          rst_n,
   ecube_route_if.slave rt
`ifdef ECUBE_ROUTE_STATS_EN
   ,
   input  logic         stat_clr,
   output logic [79:0]  stat_cnt
`endif
);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
   logic [DATA_W+3:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic [3:0]        head_xor;
   logic [DATA_W-1:0] head_data;
   logic [4:0]        sel;
   logic              non_empty, push, pop;
   always_comb begin
      {head_xor, head_data} = mem_q[rd_ptr_q];
      non_empty      = count_q != '0;
      // x & -x isolates the lowest set bit, which is the e-cube dimension
      sel            = head_xor == 4'd0 ? 5'b10000 : {1'b0, head_xor & (~head_xor + 4'd1)};
      rt.in_ready    = count_q != FULL;
      rt.out_valid   = non_empty ? sel : 5'd0;
      rt.out_data    = non_empty ? head_data : '0;
      rt.out_xor_rem = non_empty ? head_xor & ~sel[3:0] : 4'd0;
      rt.fifo_count  = count_q;
      push           = rt.in_valid & rt.in_ready;
      pop            = |(rt.out_valid & rt.out_ready);
      wr_ptr_d       = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d       = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d        = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
   end
   // Payload storage needs no reset: every output is gated by the occupancy count
   always_ff @(posedge clk)
      if (push) mem_q[wr_ptr_q] <= {rt.in_xor, rt.in_data};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
`ifdef ECUBE_ROUTE_STATS_EN
   for (genvar p = 0; p < 5; p++) begin : g_stat
      logic [15:0] cnt_q, cnt_d;
      always_comb
         cnt_d = stat_clr ? 16'd0 :
                 (rt.out_valid[p] && rt.out_ready[p] && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) cnt_q <= 16'd0;
         else        cnt_q <= cnt_d;
      assign stat_cnt[16*p +: 16] = cnt_q;
   end
`endif
endmodule

// File: tb/tb_ecube_route_stage.sv
// tb_ecube_route_stage: vector table plus scoreboard bench for ecube_route_stage (stats checks when ECUBE_ROUTE_STATS_EN is defined).
module tb_ecube_route_stage;
   logic clk = 1'b0;
   logic rst_n;
`ifdef ECUBE_ROUTE_STATS_EN
   logic        stat_clr;
   logic [79:0] stat_cnt;
`endif
   int n_chk = 0;
   int n_fail = 0;
   logic [16:0] sb [$];
   logic [16:0] exp_e;
   logic [8:0]  r;

   typedef struct {
      logic [3:0] x;
      logic [7:0] d;
      logic [4:0] port;
      logic [3:0] rem;
   } vec_t;
   vec_t vec [8];

   always #5 clk = ~clk;

   ecube_route_if #(.DATA_W(8), .DEPTH(4)) rt ();

   ecube_route_stage #(.DATA_W(8), .DEPTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rt       (rt)
`ifdef ECUBE_ROUTE_STATS_EN
      ,
      .stat_clr (stat_clr),
      .stat_cnt (stat_cnt)
`endif
   );

   function automatic logic [8:0] exp_route(input logic [3:0] x);
      logic [3:0] rem;
      rem = x;
      for (int i = 0; i < 4; i++)
         if (x[i]) begin
            rem[i] = 1'b0;
            return {5'(1 << i), rem};
         end
      return {5'b10000, 4'b0000};
   endfunction

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && rt.fifo_count != 0; k++) tick();
      check("drain_empty", 80'(rt.fifo_count), 80'd0);
   endtask

   // Scoreboard: expected {port, rem, data} queued on accept, compared on every pop
   always @(negedge clk)
      if (rst_n) begin
         if (|(rt.out_valid & rt.out_ready)) begin
            n_chk++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL sb_underflow: got %0h expected nothing", {rt.out_valid, rt.out_xor_rem, rt.out_data});
            end else begin
               exp_e = sb.pop_front();
               if ({rt.out_valid, rt.out_xor_rem, rt.out_data} !== exp_e) begin
                  n_fail++;
                  $display("FAIL sb_pop: got %0h expected %0h", {rt.out_valid, rt.out_xor_rem, rt.out_data}, exp_e);
               end
            end
         end
         if (rt.in_valid && rt.in_ready) begin
            r = exp_route(rt.in_xor);
            sb.push_back({r, rt.in_data});
         end
      end

   initial begin
      vec[0] = '{4'b0000, 8'hA5, 5'b10000, 4'b0000};
      vec[1] = '{4'b0110, 8'h11, 5'b00010, 4'b0100};
      vec[2] = '{4'b1000, 8'h22, 5'b01000, 4'b0000};
      vec[3] = '{4'b0001, 8'h33, 5'b00001, 4'b0000};
      vec[4] = '{4'b1111, 8'h44, 5'b00001, 4'b1110};
      vec[5] = '{4'b1100, 8'h55, 5'b00100, 4'b1000};
      vec[6] = '{4'b1010, 8'h66, 5'b00010, 4'b1000};
      vec[7] = '{4'b0101, 8'h77, 5'b00001, 4'b0100};
      rst_n = 1'b0;
      rt.in_valid = 1'b0;
      rt.in_xor = 4'd0;
      rt.in_data = 8'd0;
      rt.out_ready = 5'd0;
`ifdef ECUBE_ROUTE_STATS_EN
      stat_clr = 1'b0;
`endif
      #12;
      check("rst_out_valid", 80'(rt.out_valid), 80'd0);
      check("rst_in_ready", 80'(rt.in_ready), 80'd1);
      check("rst_count", 80'(rt.fifo_count), 80'd0);
      check("rst_out_data", 80'(rt.out_data), 80'd0);
      check("rst_xor_rem", 80'(rt.out_xor_rem), 80'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      // single-flit vectors, each routed and popped immediately
      for (int i = 0; i < 8; i++) begin
         rt.in_valid = 1'b1;
         rt.in_xor = vec[i].x;
         rt.in_data = vec[i].d;
         rt.out_ready = 5'b11111;
         tick();
         rt.in_valid = 1'b0;
         check("vec_out_valid", 80'(rt.out_valid), 80'(vec[i].port));
         check("vec_out_data", 80'(rt.out_data), 80'(vec[i].d));
         check("vec_xor_rem", 80'(rt.out_xor_rem), 80'(vec[i].rem));
         check("vec_count1", 80'(rt.fifo_count), 80'd1);
         tick();
         check("vec_count0", 80'(rt.fifo_count), 80'd0);
         check("vec_idle_valid", 80'(rt.out_valid), 80'd0);
      end
      // fill to DEPTH, hold a fifth flit upstream, then drain in order
      rt.out_ready = 5'd0;
      for (int i = 0; i < 4; i++) begin
         rt.in_valid = 1'b1;
         rt.in_xor = 4'(i + 1);
         rt.in_data = 8'(8'h80 + i);
         tick();
      end
      check("full_count", 80'(rt.fifo_count), 80'd4);
      check("full_in_ready", 80'(rt.in_ready), 80'd0);
      rt.in_xor = 4'd5;
      rt.in_data = 8'h84;
      tick();
      tick();
      check("full_hold_count", 80'(rt.fifo_count), 80'd4);
      check("full_hold_ready", 80'(rt.in_ready), 80'd0);
      rt.out_ready = 5'b11111;
      tick();
      check("full_pop_count", 80'(rt.fifo_count), 80'd3);
      check("full_pop_ready", 80'(rt.in_ready), 80'd1);
      tick();
      check("full_pushpop_count", 80'(rt.fifo_count), 80'd3);
      rt.in_valid = 1'b0;
      drain();
      // stall on port 2 while other ports are ready
      rt.out_ready = 5'b11011;
      rt.in_valid = 1'b1;
      rt.in_xor = 4'b0100;
      rt.in_data = 8'h5A;
      tick();
      rt.in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("stall_valid", 80'(rt.out_valid), 80'b00100);
         check("stall_data", 80'(rt.out_data), 80'h5A);
         check("stall_rem", 80'(rt.out_xor_rem), 80'd0);
         check("stall_count", 80'(rt.fifo_count), 80'd1);
         tick();
      end
      rt.out_ready = 5'b11111;
      tick();
      check("stall_release_count", 80'(rt.fifo_count), 80'd0);
      // steady push+pop at count 2, pointers wrap
      rt.out_ready = 5'd0;
      for (int i = 0; i < 2; i++) begin
         rt.in_valid = 1'b1;
         rt.in_xor = 4'(i + 9);
         rt.in_data = 8'(8'hB0 + i);
         tick();
      end
      check("pp_pre_count", 80'(rt.fifo_count), 80'd2);
      rt.out_ready = 5'b11111;
      for (int k = 0; k < 10; k++) begin
         rt.in_xor = 4'(k);
         rt.in_data = 8'(8'hC0 + k);
         tick();
         check("pp_count", 80'(rt.fifo_count), 80'd2);
      end
      rt.in_valid = 1'b0;
      drain();
      // asynchronous reset with three flits buffered
      rt.out_ready = 5'd0;
      for (int i = 0; i < 3; i++) begin
         rt.in_valid = 1'b1;
         rt.in_xor = 4'(i);
         rt.in_data = 8'(8'hE0 + i);
         tick();
      end
      rt.in_valid = 1'b0;
      check("ar_pre_count", 80'(rt.fifo_count), 80'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_out_valid", 80'(rt.out_valid), 80'd0);
      check("ar_in_ready", 80'(rt.in_ready), 80'd1);
      check("ar_count", 80'(rt.fifo_count), 80'd0);
      check("ar_out_data", 80'(rt.out_data), 80'd0);
      check("ar_xor_rem", 80'(rt.out_xor_rem), 80'd0);
      sb.delete();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      check("ar_post_ready", 80'(rt.in_ready), 80'd1);
      check("ar_post_count", 80'(rt.fifo_count), 80'd0);
      check("ar_post_valid", 80'(rt.out_valid), 80'd0);
`ifdef ECUBE_ROUTE_STATS_EN
      check("st_after_reset", stat_cnt, 80'd0);
      rt.out_ready = 5'b11111;
      for (int i = 0; i < 4; i++) begin
         rt.in_valid = 1'b1;
         rt.in_xor = i < 3 ? 4'b0001 : 4'b0000;
         rt.in_data = 8'(8'h10 + i);
         tick();
      end
      rt.in_valid = 1'b0;
      drain();
      check("st_port0", 80'(stat_cnt[15:0]), 80'd3);
      check("st_port4", 80'(stat_cnt[79:64]), 80'd1);
      check("st_mid", 80'(stat_cnt[63:16]), 80'd0);
      rt.out_ready = 5'd0;
      rt.in_valid = 1'b1;
      rt.in_xor = 4'b0001;
      rt.in_data = 8'h99;
      tick();
      rt.in_valid = 1'b0;
      rt.out_ready = 5'b11111;
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      check("st_clr_priority", stat_cnt, 80'd0);
      check("st_clr_count", 80'(rt.fifo_count), 80'd0);
      rt.in_valid = 1'b1;
      rt.in_xor = 4'b0001;
      for (int k = 0; k < 65535; k++) begin
         rt.in_data = 8'(k);
         tick();
      end
      rt.in_valid = 1'b0;
      drain();
      check("st_reach_max", 80'(stat_cnt[15:0]), 80'hFFFF);
      rt.in_valid = 1'b1;
      rt.in_data = 8'h42;
      tick();
      rt.in_valid = 1'b0;
      drain();
      check("st_saturate", 80'(stat_cnt[15:0]), 80'hFFFF);
      check("st_others", 80'(stat_cnt[79:16]), 80'd0);
`endif
      check("sb_empty", 80'(sb.size()), 80'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
